// File: rtl/tlu_tx_multi.sv
// Multi-channel TLU transmitter: fans one trigger out to N DUT channels,
// each running a pulse-only or handshake/ID-readout protocol.
module tlu_tx_multi #(
  parameter int              N_CH     = 4,
  parameter int              ID_WIDTH = 15,
  parameter logic [N_CH-1:0] INV_OUT  = '0,
  parameter int              HOLDOFF  = 4
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST_N,
  input  logic [N_CH-1:0]     ENABLE,
  input  logic [N_CH-1:0]     MODE,
  input  logic                TRIG,
  input  logic [ID_WIDTH-1:0] TRIG_ID,
  input  logic [15:0]         CONF_TIME_OUT,
  input  logic [7:0]          CONF_TRIG_LEN,
  output logic                READY,
  output logic                TRIG_ACCEPTED,
  output logic [N_CH-1:0]     TIME_OUT,
  input  logic [N_CH-1:0]     TLU_CLOCK,
  input  logic [N_CH-1:0]     TLU_BUSY,
  output logic [N_CH-1:0]     TLU_TRIGGER,
  output logic [N_CH-1:0]     TLU_RESET
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_READ,
    S_HOLD
  } state_t;

  localparam logic [15:0] HOLD_CNT = 16'(HOLDOFF);

  logic [N_CH-1:0] w_chan_rdy;
  logic            w_accept;
  logic [7:0]      w_len;
  logic            r_acc;

  assign READY         = SYS_RST_N & (&w_chan_rdy);
  assign w_accept      = TRIG & READY;
  assign w_len         = (CONF_TRIG_LEN == 8'd0) ? 8'd1 : CONF_TRIG_LEN;
  assign TRIG_ACCEPTED = r_acc;
  assign TLU_RESET     = INV_OUT;

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) r_acc <= 1'b0;
    else            r_acc <= w_accept;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t            r_state, w_next;
    logic [ID_WIDTH:0] r_sr, w_sr;
    logic [15:0]       r_cnt, w_cnt;
    logic              r_mode, w_mode;
    logic              r_to_en, w_to_en;
    logic              r_trig_o, w_trig;
    logic              r_to, w_to;
    logic              r_clk_m, r_clk_s, r_clk_d;
    logic              r_busy_m, r_busy_s;
    logic              w_clk_rise;

    assign w_clk_rise    = r_clk_s & ~r_clk_d;
    assign w_chan_rdy[g] = ~ENABLE[g] | ((r_state == S_IDLE) & ~r_clk_s);
    assign TLU_TRIGGER[g] = r_trig_o;
    assign TIME_OUT[g]    = r_to;

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
        r_clk_m  <= 1'b0;
        r_clk_s  <= 1'b0;
        r_clk_d  <= 1'b0;
        r_busy_m <= 1'b0;
        r_busy_s <= 1'b0;
      end else begin
        r_clk_m  <= TLU_CLOCK[g] ^ INV_OUT[g];
        r_clk_s  <= r_clk_m;
        r_clk_d  <= r_clk_s;
        r_busy_m <= TLU_BUSY[g] ^ INV_OUT[g];
        r_busy_s <= r_busy_m;
      end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
        r_state  <= S_IDLE;
        r_sr     <= '0;
        r_cnt    <= '0;
        r_mode   <= 1'b0;
        r_to_en  <= 1'b0;
        r_trig_o <= INV_OUT[g];
        r_to     <= 1'b0;
      end else begin
        r_state  <= w_next;
        r_sr     <= w_sr;
        r_cnt    <= w_cnt;
        r_mode   <= w_mode;
        r_to_en  <= w_to_en;
        r_trig_o <= w_trig ^ INV_OUT[g];
        r_to     <= w_to;
      end
    end

    always_comb begin
      w_next  = r_state;
      w_sr    = r_sr;
      w_cnt   = r_cnt;
      w_mode  = r_mode;
      w_to_en = r_to_en;
      w_to    = 1'b0;
      w_trig  = 1'b0;
      if (!ENABLE[g]) begin
        w_next = S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              w_next  = S_TRIG;
              w_sr    = {TRIG_ID, 1'b0};
              w_mode  = MODE[g];
              w_to_en = |CONF_TIME_OUT;
              w_cnt   = MODE[g] ? CONF_TIME_OUT : {8'd0, w_len};
            end
          end
          S_TRIG: begin
            if (!r_mode) begin
              if (r_cnt <= 16'd1) begin
                w_next = S_HOLD;
                w_cnt  = HOLD_CNT;
              end else begin
                w_cnt = r_cnt - 16'd1;
              end
            end else if (r_to_en && r_cnt == 16'd1) begin
              // timeout wins over a same-cycle busy
              w_next = S_IDLE;
              w_to   = 1'b1;
            end else if (r_busy_s) begin
              w_next = S_READ;
            end else if (r_to_en) begin
              w_cnt = r_cnt - 16'd1;
            end
          end
          S_READ: begin
            if (w_clk_rise) w_sr = {1'b0, r_sr[ID_WIDTH:1]};
            if (!r_busy_s) begin
              w_next = S_HOLD;
              w_cnt  = HOLD_CNT;
            end
          end
          S_HOLD: begin
            if (r_cnt <= 16'd1) w_next = S_IDLE;
            else                w_cnt  = r_cnt - 16'd1;
          end
        endcase
      end
      unique case (w_next)
        S_TRIG:  w_trig = 1'b1;
        S_READ:  w_trig = w_sr[0];
        S_IDLE:  w_trig = 1'b0;
        S_HOLD:  w_trig = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_tlu_tx_multi.sv
// Directed bench for tlu_tx_multi: two channels, ch1 polarity-inverted.
// Inputs driven and outputs sampled on the falling SYS_CLK edge.
module tb_tlu_tx_multi;

  localparam logic [1:0] INV = 2'b10;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST_N;
  logic [1:0]  ENABLE, MODE;
  logic        TRIG;
  logic [14:0] TRIG_ID;
  logic [15:0] CONF_TIME_OUT;
  logic [7:0]  CONF_TRIG_LEN;
  logic        READY, TRIG_ACCEPTED;
  logic [1:0]  TIME_OUT;
  logic [1:0]  TLU_CLOCK, TLU_BUSY;
  logic [1:0]  TLU_TRIGGER, TLU_RESET;
  logic [1:0]  dclk, dbusy;

  int n_chk  = 0;
  int n_fail = 0;

  assign TLU_CLOCK = dclk ^ INV;
  assign TLU_BUSY  = dbusy ^ INV;

  tlu_tx_multi #(
    .N_CH(2), .ID_WIDTH(15), .INV_OUT(INV), .HOLDOFF(4)
  ) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST_N(SYS_RST_N),
    .ENABLE(ENABLE), .MODE(MODE),
    .TRIG(TRIG), .TRIG_ID(TRIG_ID),
    .CONF_TIME_OUT(CONF_TIME_OUT),
    .CONF_TRIG_LEN(CONF_TRIG_LEN),
    .READY(READY), .TRIG_ACCEPTED(TRIG_ACCEPTED),
    .TIME_OUT(TIME_OUT),
    .TLU_CLOCK(TLU_CLOCK), .TLU_BUSY(TLU_BUSY),
    .TLU_TRIGGER(TLU_TRIGGER), .TLU_RESET(TLU_RESET)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] id;
  logic [14:0] dec0, dec1;
  logic [1:0]  lt, to_acc;
  int          w;

  initial begin
    SYS_RST_N = 1'b0;
    ENABLE = '0; MODE = '0; TRIG = 1'b0; TRIG_ID = '0;
    CONF_TIME_OUT = '0; CONF_TRIG_LEN = '0;
    dclk = '0; dbusy = '0;
    tick(2);
    chk("rst_ready", READY, 0);
    chk("rst_trig", TLU_TRIGGER, 2'b10);
    chk("rst_treset", TLU_RESET, 2'b10);
    chk("rst_timeout", TIME_OUT, 0);
    chk("rst_acc", TRIG_ACCEPTED, 0);
    SYS_RST_N = 1'b1;
    tick(1);
    chk("ready_none_en", READY, 1);

    // ch0 handshake readout of 0x5A5A
    ENABLE = 2'b01; MODE = 2'b01; TRIG_ID = 15'h5A5A;
    tick(1);
    chk("a_ready", READY, 1);
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    chk("a_acc", TRIG_ACCEPTED, 1);
    chk("a_trig_hi", TLU_TRIGGER, 2'b11);
    chk("a_busy_rdy", READY, 0);
    tick(1);
    chk("a_acc_pulse", TRIG_ACCEPTED, 0);
    tick(8);
    dbusy[0] = 1'b1;
    tick(3);
    chk("a_read_start", TLU_TRIGGER[0], 0);
    id = 16'h5A5A;
    for (int k = 0; k < 17; k++) begin
      dclk[0] = 1'b1;
      tick(4);
      chk($sformatf("a_bit%0d", k), TLU_TRIGGER[0],
          (k < 16) ? id[k] : 1'b0);
      dclk[0] = 1'b0;
      tick(4);
    end
    dbusy[0] = 1'b0;
    tick(6);
    chk("a_hold_rdy", READY, 0);
    chk("a_hold_trig", TLU_TRIGGER[0], 0);
    tick(1);
    chk("a_rdy_back", READY, 1);

    // ch0 handshake timeout
    CONF_TIME_OUT = 16'd20;
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    tick(19);
    chk("b_no_to_yet", TIME_OUT, 0);
    chk("b_trig_hi", TLU_TRIGGER[0], 1);
    tick(1);
    chk("b_to_pulse", TIME_OUT, 2'b01);
    chk("b_trig_lo", TLU_TRIGGER[0], 0);
    tick(1);
    chk("b_to_clear", TIME_OUT, 0);
    chk("b_ready", READY, 1);

    // ch1 pulse mode, length 0 and 5
    ENABLE = 2'b10; MODE = 2'b00; CONF_TRIG_LEN = 8'd0;
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      lt = TLU_TRIGGER ^ INV;
      if (lt[1]) w++;
      tick(1);
    end
    chk("c_width1", w, 1);
    CONF_TRIG_LEN = 8'd5;
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    w = 0;
    lt = TLU_TRIGGER ^ INV;
    if (lt[1]) w++;
    chk("c_busy_rdy", READY, 0);
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    chk("c_ignored", TRIG_ACCEPTED, 0);
    for (int i = 0; i < 20; i++) begin
      lt = TLU_TRIGGER ^ INV;
      if (lt[1]) w++;
      tick(1);
    end
    chk("c_width5", w, 5);
    chk("c_ready", READY, 1);

    // both channels handshake concurrently
    ENABLE = 2'b11; MODE = 2'b11; CONF_TIME_OUT = 16'd0;
    TRIG_ID = 15'h1234;
    tick(1);
    chk("d_idle_trig", TLU_TRIGGER, 2'b10);
    chk("d_idle_reset", TLU_RESET, 2'b10);
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    chk("d_trig_raw", TLU_TRIGGER, 2'b01);
    dbusy = 2'b11;
    tick(3);
    id = 16'h1234;
    dec0 = '0; dec1 = '0;
    for (int k = 0; k < 15; k++) begin
      dclk = 2'b11;
      tick(4);
      lt = TLU_TRIGGER ^ INV;
      dec0[k] = lt[0];
      dec1[k] = lt[1];
      dclk = 2'b00;
      tick(4);
    end
    chk("d_dec0", dec0, 15'h1234);
    chk("d_dec1", dec1, 15'h1234);
    dbusy = 2'b00;
    tick(8);
    chk("d_ready", READY, 1);
    chk("d_idle_after", TLU_TRIGGER, 2'b10);

    // reset mid-readout
    ENABLE = 2'b01; MODE = 2'b01; TRIG_ID = 15'h0003;
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    dbusy[0] = 1'b1;
    tick(3);
    dclk[0] = 1'b1;
    tick(4);
    chk("e_bit0", TLU_TRIGGER[0], 1);
    SYS_RST_N = 1'b0;
    #1;
    chk("e_rst_trig", TLU_TRIGGER, 2'b10);
    chk("e_rst_ready", READY, 0);
    chk("e_rst_to", TIME_OUT, 0);
    dclk = '0; dbusy = '0;
    tick(1);
    SYS_RST_N = 1'b1;
    tick(1);
    chk("e_rdy_after", READY, 1);

    // enable dropped during TRIG
    CONF_TIME_OUT = 16'd3;
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    chk("e_en_trig_hi", TLU_TRIGGER[0], 1);
    ENABLE = 2'b00;
    tick(1);
    chk("e_en_trig_lo", TLU_TRIGGER, 2'b10);
    to_acc = '0;
    for (int i = 0; i < 5; i++) begin
      to_acc |= TIME_OUT;
      tick(1);
    end
    chk("e_en_no_to", to_acc, 0);
    ENABLE = 2'b01; MODE = 2'b00; CONF_TRIG_LEN = 8'd2;
    CONF_TIME_OUT = 16'd0;
    tick(1);
    TRIG = 1'b1;
    tick(1);
    TRIG = 1'b0;
    chk("e_next_acc", TRIG_ACCEPTED, 1);
    chk("e_next_trig", TLU_TRIGGER[0], 1);
    tick(10);
    chk("e_final_rdy", READY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tlu_tx_multi.md
TLU_TX_MULTI -- requirements
Module: tlu_tx_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of DUT channels, 1..8.
REQ-002 SHALL have parameter ID_WIDTH, default 15: trigger ID width, 1..31.
REQ-003 SHALL have parameter INV_OUT[N_CH-1:0], default 0: per-channel polarity inversion of all four DUT-side signals.
REQ-004 SHALL have parameter HOLDOFF, default 4: idle cycles after each completed transaction.
REQ-005 SYS_CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 SYS_RST_N  in  1  reset, asynchronous, active-low.
REQ-007 ENABLE  in  N_CH  per-channel enable.
REQ-008 MODE  in  N_CH  per-channel mode: 0 = trigger pulse only, 1 = handshake with ID readout.
REQ-009 TRIG  in  1  trigger request, one-cycle strobe.
REQ-010 TRIG_ID  in  ID_WIDTH  ID latched on accepted TRIG.
REQ-011 CONF_TIME_OUT  in  16  handshake timeout in cycles; 0 disables the timeout.
REQ-012 CONF_TRIG_LEN  in  8  mode-0 pulse length in cycles; 0 is treated as 1.
REQ-013 READY  out  1  block can accept TRIG.
REQ-014 TRIG_ACCEPTED  out  1  one-cycle pulse per accepted TRIG.
REQ-015 TIME_OUT  out  N_CH  one-cycle pulse per channel timeout.
REQ-016 TLU_CLOCK, TLU_BUSY  in  N_CH each  asynchronous DUT inputs.
REQ-017 TLU_TRIGGER, TLU_RESET  out  N_CH each  DUT outputs, registered.

Function
REQ-018 TLU_CLOCK and TLU_BUSY SHALL be XORed with INV_OUT, then pass through a 2-flop synchronizer (clk_s, busy_s); the clk_s rising edge is detected on the synchronized value.
REQ-019 Each channel SHALL run an independent FSM: IDLE, TRIG, READ_ID, HOLD.
REQ-020 READY SHALL equal the AND over all channels of (!ENABLE[i] || (state==IDLE && clk_s==0)); with no channel enabled, READY=1.
REQ-021 TRIG SHALL be accepted only when TRIG && READY; otherwise it is ignored with no side effects.
REQ-022 On acceptance: TRIG_ACCEPTED=1 for one cycle; every enabled channel loads shift register SR <= {TRIG_ID,1'b0} (ID_WIDTH+1 bits) and enters TRIG at the same edge.
REQ-023 TLU_TRIGGER SHALL be registered from next-state: 1 from the edge entering TRIG; XORed with INV_OUT[i].
REQ-024 Mode 0, TRIG: held for max(CONF_TRIG_LEN,1) cycles, then HOLD; busy and clock are ignored.
REQ-025 Mode 1, TRIG: busy_s=1 -> READ_ID. Timeout (REQ-028) -> IDLE with a TIME_OUT[i] pulse. Timeout takes priority when both occur in the same cycle.
REQ-026 Mode 1, READ_ID: TLU_TRIGGER=SR[0]; on each clk_s rising edge, SR shifts right with 0 in; busy_s=0 -> HOLD. Surplus DUT clocks output 0.
REQ-027 HOLD: HOLDOFF cycles, then IDLE; TLU_TRIGGER=0.
REQ-028 Timeout counter: loaded with CONF_TIME_OUT on TRIG entry; decrements each cycle in TRIG; timeout occurs when it reaches 0 with CONF_TIME_OUT!=0. CONF_TIME_OUT=0 means wait forever.
REQ-029 ENABLE[i] deasserted in any state SHALL force IDLE at the next edge: TLU_TRIGGER=0, no TIME_OUT.
REQ-030 MODE and CONF_* SHALL be sampled at acceptance; changes mid-transaction have no effect until the next acceptance.
REQ-031 TLU_RESET[i] SHALL be a constant deasserted level (INV_OUT[i]).

Reset
REQ-032 While SYS_RST_N=0: all FSMs IDLE; SR, counters and synchronizers 0; TLU_TRIGGER=INV_OUT; TIME_OUT=0; TRIG_ACCEPTED=0; READY=0.
REQ-033 Reset assertion mid-transaction SHALL abort immediately with no TIME_OUT pulse; after release, READY rises once the synchronizers show clk_s=0.

Verification
REQ-034 N_CH=2, ch0 mode 1, TRIG_ID=0x5A5A, DUT raises busy after 10 cycles and gives 16 clocks -> TLU_TRIGGER[0] serial bits LSB-first 0,1,0,1,1,0,1,0,... matching 0x5A5A; READY returns HOLDOFF cycles after busy falls.
REQ-035 ch0 mode 1, CONF_TIME_OUT=20, busy never asserted -> TIME_OUT[0] pulses 20 cycles after TRIG entry; channel IDLE; READY=1 next cycle.
REQ-036 ch1 mode 0, CONF_TRIG_LEN=0 then 5 -> pulse widths of exactly 1 and 5 cycles; TRIG while busy-held (READY=0) -> ignored, no TRIG_ACCEPTED.
REQ-037 INV_OUT=2'b10, both channels mode 1 concurrently, ch1 inputs inverted -> both decode identical IDs; idle ch1 TLU_TRIGGER=1, TLU_RESET[1]=1.
REQ-038 SYS_RST_N pulsed low during READ_ID, and ENABLE[0] dropped during TRIG -> TLU_TRIGGER to idle level at once (reset) or next edge (enable); no TIME_OUT; next TRIG accepted normally.
